// File: rtl/ip_pkg.sv
// rtl/ip_pkg.sv - shared IPv4 receive definitions: states, error codes, header constants
package ip_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR     = 3'd1,
    S_OPT     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_DROP    = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_VERSION = 3'd1;
  localparam logic [2:0] ERR_IHL     = 3'd2;
  localparam logic [2:0] ERR_CSUM    = 3'd3;
  localparam logic [2:0] ERR_PROTO   = 3'd4;
  localparam logic [2:0] ERR_LEN     = 3'd5;
  localparam logic [2:0] ERR_TRUNC   = 3'd6;

  localparam logic [3:0] IPV4_VERSION = 4'd4;
  localparam logic [3:0] IHL_MIN      = 4'd5;

  // Byte enables for the final payload word: the top 'rem' bytes are live.
  function automatic logic [3:0] tail_keep(input logic [15:0] rem);
    case (rem)
      16'd1:   tail_keep = 4'b1000;
      16'd2:   tail_keep = 4'b1100;
      16'd3:   tail_keep = 4'b1110;
      default: tail_keep = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ipv4_hdr_checksum.sv
// rtl/ipv4_hdr_checksum.sv - one's-complement 16-bit checksum over 32-bit header words
module ipv4_hdr_checksum (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_add,
  input  logic [31:0] i_word,
  output logic        o_pass
);

  logic [19:0] r_acc;
  logic [19:0] w_base;
  logic [20:0] w_raw;
  logic [19:0] w_next;
  logic [16:0] w_f1;
  logic [15:0] w_f2;

  // Next accumulator value and the folded result including this cycle's word.
  // A carry out of bit 20 is worth 2^20 == 2^4 (mod 0xFFFF), so it re-enters as 16;
  // that keeps 15-word headers exact in a 20-bit register.
  always_comb begin
    w_base = i_clear ? 20'd0 : r_acc;
    w_raw  = {1'b0, w_base} + {5'd0, i_word[31:16]} + {5'd0, i_word[15:0]};
    w_next = i_add ? (w_raw[19:0] + {15'd0, w_raw[20], 4'd0}) : w_base;
    w_f1   = {1'b0, w_next[15:0]} + {13'd0, w_next[19:16]};
    w_f2   = w_f1[15:0] + {15'd0, w_f1[16]};
  end

  assign o_pass = (w_f2 == 16'hFFFF);

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_acc <= 20'd0;
    else        r_acc <= w_next;
  end

endmodule

// File: rtl/ipv4_rx_dispatch.sv
// rtl/ipv4_rx_dispatch.sv - IPv4 header parse/check and payload dispatch to protocol channels
module ipv4_rx_dispatch
  import ip_pkg::*;
#(
  parameter int                    NUM_CH     = 2,
  parameter logic [8*NUM_CH-1:0]   PROTO_LIST = 16'h06_11,
  parameter int                    CH_W       = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [3:0]        version,
  output logic [3:0]        ihl,
  output logic [15:0]       total_length,
  output logic [7:0]        ttl,
  output logic [7:0]        protocol,
  output logic [31:0]       src_ip,
  output logic [31:0]       dest_ip,
  output logic              hdr_valid,
  output logic [31:0]       out_data,
  output logic [3:0]        out_keep,
  output logic              out_valid,
  output logic              out_last,
  output logic [CH_W-1:0]   out_ch,
  input  logic [NUM_CH-1:0] out_ready,
  output logic              ok,
  output logic [2:0]        err,
  output logic              fin
);

  state_t          r_state;
  logic            r_live;
  logic [3:0]      r_widx;
  logic [15:0]     r_rem;
  logic [CH_W-1:0] r_ch;
  logic            r_ok;
  logic [2:0]      r_err;
  logic            r_hdr_valid;
  logic            r_fin;
  logic [3:0]      r_version;
  logic [3:0]      r_ihl;
  logic [15:0]     r_total_length;
  logic [7:0]      r_ttl;
  logic [7:0]      r_protocol;
  logic [31:0]     r_src_ip;
  logic [31:0]     r_dest_ip;

  logic            w_accept;
  logic            w_in_ready;
  logic            w_final_hdr;
  logic [5:0]      w_hdr_len;
  logic [15:0]     w_plen;
  logic            w_last_beat;
  logic            w_csum_pass;
  logic            w_hit;
  logic [CH_W-1:0] w_ch;
  logic [2:0]      w_err;

  ipv4_hdr_checksum u_csum (
    .clk     (clk),
    .rst_n   (reset),
    .i_clear (r_state == S_IDLE && w_accept),
    .i_add   (w_accept && (r_state == S_IDLE || r_state == S_HDR || r_state == S_OPT)),
    .i_word  (in_data),
    .o_pass  (w_csum_pass)
  );

  // Ready per state; held low until the first clock after reset release.
  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      S_IDLE, S_HDR, S_OPT, S_DROP: w_in_ready = r_live;
      S_PAYLOAD:                    w_in_ready = out_ready[r_ch];
      default:                      w_in_ready = 1'b0;
    endcase
  end

  assign in_ready    = w_in_ready;
  assign w_accept    = in_valid && w_in_ready;
  assign w_hdr_len   = {r_ihl, 2'b00};
  assign w_plen      = r_total_length - {10'd0, w_hdr_len};
  assign w_last_beat = (r_rem <= 16'd4);
  assign w_final_hdr = (r_state == S_HDR && r_widx == 4'd4 && r_ihl <= IHL_MIN) ||
                       (r_state == S_OPT && r_widx == r_ihl - 4'd1);

  // Protocol table lookup: scan downward so the lowest matching index wins.
  always_comb begin
    w_hit = 1'b0;
    w_ch  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (PROTO_LIST[8*i +: 8] == r_protocol) begin
        w_hit = 1'b1;
        w_ch  = CH_W'(i);
      end
    end
  end

  // Header verdict for the final header word, in priority order.
  always_comb begin
    if (r_version != IPV4_VERSION)                    w_err = ERR_VERSION;
    else if (r_ihl < IHL_MIN)                         w_err = ERR_IHL;
    else if (!w_csum_pass)                            w_err = ERR_CSUM;
    else if (!w_hit)                                  w_err = ERR_PROTO;
    else if (r_total_length < {10'd0, w_hdr_len})     w_err = ERR_LEN;
    else if (in_last && w_plen != 16'd0)              w_err = ERR_TRUNC;
    else                                              w_err = ERR_NONE;
  end

  // Payload pass-through, only live while forwarding.
  always_comb begin
    out_valid = 1'b0;
    out_data  = 32'd0;
    out_keep  = 4'd0;
    out_last  = 1'b0;
    if (r_state == S_PAYLOAD) begin
      out_valid = in_valid;
      out_data  = in_data;
      out_keep  = w_last_beat ? tail_keep(r_rem) : 4'b1111;
      out_last  = w_last_beat || in_last;
    end
  end

  assign out_ch       = r_ch;
  assign ok           = r_ok;
  assign err          = r_err;
  assign hdr_valid    = r_hdr_valid;
  assign fin          = r_fin;
  assign version      = r_version;
  assign ihl          = r_ihl;
  assign total_length = r_total_length;
  assign ttl          = r_ttl;
  assign protocol     = r_protocol;
  assign src_ip       = r_src_ip;
  assign dest_ip      = r_dest_ip;

  // Packet state machine with registered header fields, verdict and pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_live         <= 1'b0;
      r_widx         <= 4'd0;
      r_rem          <= 16'd0;
      r_ch           <= '0;
      r_ok           <= 1'b0;
      r_err          <= ERR_NONE;
      r_hdr_valid    <= 1'b0;
      r_fin          <= 1'b0;
      r_version      <= 4'd0;
      r_ihl          <= 4'd0;
      r_total_length <= 16'd0;
      r_ttl          <= 8'd0;
      r_protocol     <= 8'd0;
      r_src_ip       <= 32'd0;
      r_dest_ip      <= 32'd0;
    end else begin
      r_live      <= 1'b1;
      r_hdr_valid <= 1'b0;
      r_fin       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_version      <= in_data[31:28];
            r_ihl          <= in_data[27:24];
            r_total_length <= in_data[15:0];
            r_ttl          <= 8'd0;
            r_protocol     <= 8'd0;
            r_src_ip       <= 32'd0;
            r_dest_ip      <= 32'd0;
            r_ok           <= 1'b0;
            r_err          <= ERR_NONE;
            r_widx         <= 4'd1;
            if (in_last) begin
              r_err       <= ERR_TRUNC;
              r_hdr_valid <= 1'b1;
              r_fin       <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_state <= S_HDR;
            end
          end
        end
        S_HDR, S_OPT: begin
          if (w_accept) begin
            r_widx <= r_widx + 4'd1;
            if (r_state == S_HDR) begin
              case (r_widx)
                4'd2: begin
                  r_ttl      <= in_data[31:24];
                  r_protocol <= in_data[23:16];
                end
                4'd3:    r_src_ip  <= in_data;
                4'd4:    r_dest_ip <= in_data;
                default: ;
              endcase
            end
            if (w_final_hdr) begin
              r_hdr_valid <= 1'b1;
              r_err       <= w_err;
              r_ok        <= (w_err == ERR_NONE);
              r_ch        <= w_ch;
              r_rem       <= w_plen;
              if (w_err == ERR_NONE && w_plen != 16'd0) begin
                r_state <= S_PAYLOAD;
              end else if (in_last) begin
                r_fin   <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_state <= S_DROP;
              end
            end else if (in_last) begin
              r_err       <= ERR_TRUNC;
              r_hdr_valid <= 1'b1;
              r_fin       <= 1'b1;
              r_state     <= S_DONE;
            end else if (r_state == S_HDR && r_widx == 4'd4) begin
              r_state <= S_OPT;
            end
          end
        end
        S_PAYLOAD: begin
          if (w_accept) begin
            if (in_last && !w_last_beat) begin
              r_err   <= ERR_TRUNC;
              r_ok    <= 1'b0;
              r_fin   <= 1'b1;
              r_state <= S_DONE;
            end else if (w_last_beat) begin
              if (in_last) begin
                r_fin   <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_state <= S_DROP;
              end
            end else begin
              r_rem <= r_rem - 16'd4;
            end
          end
        end
        S_DROP: begin
          if (w_accept && in_last) begin
            r_fin   <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ipv4_rx_dispatch.sv
// tb/tb_ipv4_rx_dispatch.sv - self-checking bench for ipv4_rx_dispatch
module tb_ipv4_rx_dispatch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [3:0]  version, ihl;
  logic [15:0] total_length;
  logic [7:0]  ttl, protocol;
  logic [31:0] src_ip, dest_ip;
  logic        hdr_valid;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_valid, out_last;
  logic [0:0]  out_ch;
  logic [1:0]  out_ready = 2'b11;
  logic        ok;
  logic [2:0]  err;
  logic        fin;

  ipv4_rx_dispatch #(.NUM_CH(2), .PROTO_LIST(16'h06_11), .CH_W(1)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .version(version), .ihl(ihl), .total_length(total_length),
    .ttl(ttl), .protocol(protocol), .src_ip(src_ip), .dest_ip(dest_ip),
    .hdr_valid(hdr_valid), .out_data(out_data), .out_keep(out_keep), .out_valid(out_valid),
    .out_last(out_last), .out_ch(out_ch), .out_ready(out_ready), .ok(ok), .err(err), .fin(fin)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] pkt[$];
  beat_t       exp_q[$];
  logic [2:0]  exp_hdr_err;
  logic [2:0]  exp_final_err;
  logic        exp_final_ok;
  logic        exp_ch;
  logic [31:0] exp_src;
  int          fin_cnt = 0;
  int          hv_cnt = 0;
  int          n_beats = 0;
  logic [3:0]  last_keep = 4'd0;
  bit          tog_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected behaviour of one packet from the header rules and payload length.
  task automatic model_pkt();
    int hw, s, plen, nb, avail, rem;
    logic [3:0] ver, hl;
    logic [15:0] tl;
    logic [7:0] pr;
    bit known, trunc;
    beat_t b;
    exp_q.delete();
    ver   = pkt[0][31:28];
    hl    = pkt[0][27:24];
    tl    = pkt[0][15:0];
    pr    = (pkt.size() > 2) ? pkt[2][23:16] : 8'd0;
    exp_src = (pkt.size() > 3) ? pkt[3] : 32'd0;
    hw    = (hl < 4'd5) ? 5 : int'(hl);
    known = (pr == 8'h11) || (pr == 8'h06);
    exp_ch = (pr == 8'h06);
    plen  = int'(tl) - 4 * int'(hl);
    trunc = 1'b0;
    if (pkt.size() < hw) begin
      exp_hdr_err = 3'd6;
    end else begin
      s = 0;
      for (int i = 0; i < hw; i++) s += int'(pkt[i][31:16]) + int'(pkt[i][15:0]);
      while (s > 65535) s = (s & 65535) + (s >> 16);
      if (ver != 4'd4)                        exp_hdr_err = 3'd1;
      else if (hl < 4'd5)                     exp_hdr_err = 3'd2;
      else if (s != 65535)                    exp_hdr_err = 3'd3;
      else if (!known)                        exp_hdr_err = 3'd4;
      else if (plen < 0)                      exp_hdr_err = 3'd5;
      else if (pkt.size() == hw && plen > 0)  exp_hdr_err = 3'd6;
      else                                    exp_hdr_err = 3'd0;
    end
    if (exp_hdr_err == 3'd0) begin
      nb = (plen + 3) / 4;
      avail = pkt.size() - hw;
      for (int j = 0; j < nb && j < avail; j++) begin
        rem = plen - 4 * j;
        b.d = pkt[hw + j];
        b.l = (j == nb - 1) || (j == avail - 1);
        b.k = (rem >= 4) ? 4'hF : 4'(4'hF << (4 - rem));
        if (j == avail - 1 && j < nb - 1) begin
          b.k = 4'hF;
          trunc = 1'b1;
        end
        exp_q.push_back(b);
      end
    end
    exp_final_err = trunc ? 3'd6 : exp_hdr_err;
    exp_final_ok  = (exp_final_err == 3'd0);
  endtask

  task automatic make_pkt(input logic [31:0] w0, input logic [31:0] w2, input int nopt, input int npay);
    pkt.delete();
    pkt.push_back(w0);
    pkt.push_back(32'h0000_4000);
    pkt.push_back(w2);
    pkt.push_back(32'hC0A8_0001);
    pkt.push_back(32'hC0A8_00C7);
    for (int i = 0; i < nopt; i++) pkt.push_back(32'h0102_0304);
    for (int i = 0; i < npay; i++) pkt.push_back(32'hA5000000 + 32'(i * 32'h0101));
  endtask

  // Drive the first n words of pkt; each word waits (bounded) for acceptance.
  task automatic send(input int n);
    int cyc;
    bit acc;
    for (int i = 0; i < n; i++) begin
      in_data  = pkt[i];
      in_valid = 1'b1;
      in_last  = (i == pkt.size() - 1);
      cyc = 0;
      forever begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        if (acc) break;
        cyc++;
        if (cyc > 200) begin
          n_checks++;
          n_fail++;
          $display("FAIL accept_timeout: word %0d not accepted, required within 200 cycles", i);
          in_valid = 1'b0;
          in_last  = 1'b0;
          return;
        end
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_pkt(input bit tog);
    int fin0, hv0;
    model_pkt();
    fin0 = fin_cnt;
    hv0  = hv_cnt;
    n_beats = 0;
    tog_en = tog;
    send(pkt.size());
    tog_en = 1'b0;
    for (int c = 0; c < 20 && fin_cnt == fin0; c++) @(posedge clk);
    @(posedge clk);
    #1;
    check("fin_count", 32'(fin_cnt - fin0), 32'd1);
    check("hdr_valid_count", 32'(hv_cnt - hv0), 32'd1);
    check("beats_outstanding", 32'(exp_q.size()), 32'd0);
    check("ok_level", 32'(ok), 32'(exp_final_ok));
    check("err_level", 32'(err), 32'(exp_final_err));
  endtask

  // out_ready[0] toggles every cycle when enabled, else both channels ready.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tog_en) out_ready[0] = ~out_ready[0];
      else        out_ready = 2'b11;
    end
  end

  // Compare process: payload beats against the model queue, header verdict, fin count.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (out_valid) begin
          check("in_ready_follows_out_ready", 32'(in_ready), 32'(out_ready[out_ch]));
          if (in_ready) begin
            check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
              b = exp_q.pop_front();
              check("out_data", out_data, b.d);
              check("out_keep", 32'(out_keep), 32'(b.k));
              check("out_last", 32'(out_last), 32'(b.l));
              check("out_ch", 32'(out_ch), 32'(exp_ch));
              n_beats++;
              last_keep = out_keep;
            end
          end
        end
        if (hdr_valid) begin
          hv_cnt++;
          check("hdr_err", 32'(err), 32'(exp_hdr_err));
          check("hdr_ok", 32'(ok), 32'(exp_hdr_err == 3'd0));
          if (exp_hdr_err != 3'd6) check("hdr_src_ip", src_ip, exp_src);
        end
        if (fin) fin_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fin0;
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_ok_err_fin", {28'd0, ok, err}, 32'd0);
    check("rst_hdr", {24'd0, version, ihl}, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Basic UDP packet, 95-byte payload.
    make_pkt(32'h4500_0073, 32'h4011_B861, 0, 24);
    model_pkt();
    check("model_beats_p1", 32'(exp_q.size()), 32'd24);
    run_pkt(1'b0);
    check("p1_beats", 32'(n_beats), 32'd24);
    check("p1_last_keep", 32'(last_keep), 32'b1110);
    check("p1_src_ip", src_ip, 32'hC0A8_0001);
    check("p1_ok", 32'(ok), 32'd1);
    check("p1_err", 32'(err), 32'd0);
    check("p1_out_ch", 32'(out_ch), 32'd0);
    check("p1_protocol", 32'(protocol), 32'h11);

    // Same packet under back-pressure.
    make_pkt(32'h4500_0073, 32'h4011_B861, 0, 24);
    run_pkt(1'b1);
    check("p2_beats", 32'(n_beats), 32'd24);

    // Bad checksum.
    make_pkt(32'h4500_0073, 32'h4011_B862, 0, 24);
    run_pkt(1'b0);
    check("p3_err", 32'(err), 32'd3);
    check("p3_ok", 32'(ok), 32'd0);
    check("p3_beats", 32'(n_beats), 32'd0);

    // Unknown protocol 0x01.
    make_pkt(32'h4500_0073, 32'h4001_B871, 0, 24);
    run_pkt(1'b0);
    check("p4_err", 32'(err), 32'd4);

    // TCP goes to channel 1.
    make_pkt(32'h4500_0073, 32'h4006_B86C, 0, 24);
    run_pkt(1'b0);
    check("p5_out_ch", 32'(out_ch), 32'd1);
    check("p5_ok", 32'(ok), 32'd1);

    // IHL=6 with one option, 4-byte payload, two padding words.
    make_pkt(32'h4600_001C, 32'h4011_B3B2, 1, 3);
    run_pkt(1'b0);
    check("p6_beats", 32'(n_beats), 32'd1);
    check("p6_keep", 32'(last_keep), 32'hF);
    check("p6_ok", 32'(ok), 32'd1);
    check("p6_ihl", 32'(ihl), 32'd6);

    // Reset in the middle of the payload, then a fresh packet.
    make_pkt(32'h4500_0073, 32'h4011_B861, 0, 24);
    model_pkt();
    fin0 = fin_cnt;
    send(15);
    reset = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ok_err_fin", {27'd0, hdr_valid, ok, err}, 32'd0);
    check("mid_rst_src_ip", src_ip, 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    check("mid_rst_no_fin", 32'(fin_cnt - fin0), 32'd0);
    #1 reset = 1'b1;
    make_pkt(32'h4500_0073, 32'h4011_B861, 0, 24);
    run_pkt(1'b0);
    check("p7_ok", 32'(ok), 32'd1);
    check("p7_beats", 32'(n_beats), 32'd24);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ipv4_rx_dispatch.md
Name: ipv4_rx_dispatch

Overview:
Parametrised successor to the fixed IP front end of combine_decoder. It takes a 32-bit IPv4 packet stream over a valid/ready handshake and parses the header, including IHL options. It verifies the header checksum and field sanity, then forwards the payload to one of NUM_CH protocol channels selected from a protocol-number table. It sits between the receive buffer and the per-protocol decoders (TCP, UDP, future ICMP), replacing the hard-wired TCP/UDP split.

Parameters:
NUM_CH, 2, number of payload channels (1..8).
PROTO_LIST, 16'h06_11, packed 8-bit protocol numbers; byte i selects channel i (default: ch0=UDP 0x11, ch1=TCP 0x06).
CH_W, 1, width of channel index; must be at least clog2(NUM_CH), minimum 1.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
in_data  in  32  packet word, big-endian byte order.
in_valid  in  1  in_data valid.
in_last  in  1  final word of packet.
in_ready  out  1  word accepted when in_valid && in_ready.
version, ihl  out  4 each  header fields.
total_length  out  16  header field.
ttl, protocol  out  8 each  header fields.
src_ip, dest_ip  out  32 each  header fields.
hdr_valid  out  1  one-cycle pulse: header fields and err are final.
out_data  out  32  payload word.
out_keep  out  4  byte enables, bit 3 = in_data[31:24].
out_valid  out  1  payload word valid.
out_last  out  1  final payload word.
out_ch  out  CH_W  destination channel index.
out_ready  in  NUM_CH  per-channel ready; only out_ready[out_ch] is used.
ok  out  1  level; set on hdr_valid if err==0, held until next packet start.
err  out  3  0 none, 1 version, 2 IHL<5, 3 checksum, 4 unknown protocol, 5 total_length<IHL*4, 6 truncated.
fin  out  1  one-cycle pulse at end of every packet, good or bad.

Behaviour:
- Reset (reset==0, async): state IDLE. All outputs 0 except in_ready=0. Header registers and checksum accumulator cleared. Reset mid-packet abandons the packet; no fin.
- States: IDLE, HDR, OPT, PAYLOAD, DROP, DONE.
- IDLE: in_ready=1. On accept, latch word 0, clear ok/err, checksum = word0 halves, go to HDR.
- HDR: in_ready=1. Accept words 1..4. Checksum is a one's-complement sum of 16-bit halves in a 20-bit accumulator, end-around carry folded at evaluation. On word 4, go to OPT if ihl>5, else evaluate.
- OPT: accept ihl-5 words, folding each into the checksum; contents are discarded; evaluate after the last one.
- Evaluate (registered): hdr_valid pulses the cycle after the final header word is accepted. Error priority is 1 > 2 > 3 > 4 > 5; the first match sets err. Checksum passes when the folded sum equals 16'hFFFF. Channel = lowest i with PROTO_LIST byte i == protocol.
- Next state: err==0 goes to PAYLOAD. Nonzero err with in_last already seen goes to DONE, otherwise DROP.
- in_last during HDR/OPT: err=6, hdr_valid pulses, go to DONE. The header fields captured so far are left in place.
- PAYLOAD: combinational pass-through. out_valid = in_valid; in_ready = out_ready[out_ch]; out_data = in_data.
  - Remaining byte counter starts at total_length - ihl*4 and decrements by 4 per accepted word.
  - out_last = 1 when remaining <= 4. out_keep = 4'b1111, or on the last word the top (remaining) bytes set.
  - Payload length 0: no out_valid; go to DROP, or DONE if in_last was seen.
  - in_last before remaining <= 4: word forwarded with out_last=1, keep 4'b1111, err=6, ok cleared, go to DONE.
  - out_last beat without in_last (Ethernet padding): go to DROP. With in_last: go to DONE.
- DROP: in_ready=1, out_valid=0; consume until in_last, then go to DONE.
- DONE: fin=1 for one cycle, in_ready=0, then IDLE. Next packet accepted on the following cycle.
- Header outputs hold until the next packet's word 0 is accepted.

Decomposition:
- Shared package ip_pkg: state encoding, error code constants, IPV4_VERSION=4, IHL_MIN=5.
- One sub-module, ipv4_hdr_checksum: accumulate/clear/fold, output pass flag. Reusable by the TCP/UDP decoders.

Test Plan:
- Header 45000073 00004000 4011B861 C0A80001 C0A800C7, then 24 payload words, last with in_last. Expect ok=1, err=0, out_ch=0, src_ip=C0A80001, 24 out beats, final out_keep=4'b1110, one fin.
- Same packet with out_ready[0] toggling every other cycle. Expect in_ready to follow out_ready[0], all 24 words in order, none duplicated.
- Checksum field changed to B862. Expect hdr_valid with err=3, ok=0, no out_valid, all words consumed, fin after in_last.
- Protocol 0x01 with the checksum recomputed. Expect err=4. Protocol 0x06 variant: out_ch=1, ok=1.
- IHL=6 with one option word (checksum valid), total_length=28. Expect option skipped, 1 payload beat, keep 4'b1111. Then 2 padding words are dropped and fin follows in_last.
- Reset asserted on payload word 10, then a fresh packet. Expect outputs at reset values immediately, no fin for the aborted packet, and the second packet decoded with ok=1.
